// File: rtl/add_round_key_stage_pkg.sv
// add_round_key_stage_pkg
//   Shared constants and the buffer entry type for the AddRoundKey stage.
//   AES_STATE_W : width of one AES state (128 bits, column 0 in bits 127:96)
//   ROUND_W     : width of the round number carried with each entry
//   ark_entry_t : {state, round[, parity]} as held in the output buffer
//   Optional feature macro: ARK_PARITY_EN adds a per-byte even parity field
//   to the entry and the byte_parity helper used to fill it.
package add_round_key_stage_pkg;

  localparam int AES_STATE_W = 128;
  localparam int ROUND_W     = 4;

`ifdef ARK_PARITY_EN
  localparam int PARITY_W = AES_STATE_W / 8;
`endif

  typedef struct packed {
    logic [AES_STATE_W-1:0] state;
    logic [ROUND_W-1:0]     round;
`ifdef ARK_PARITY_EN
    logic [PARITY_W-1:0]    parity;
`endif
  } ark_entry_t;

`ifdef ARK_PARITY_EN
  // Bit i is the XOR of byte i (bits 8i+7:8i), so the byte plus its parity
  // bit always holds an even number of ones.
  function automatic logic [PARITY_W-1:0] byte_parity(input logic [AES_STATE_W-1:0] s);
    logic [PARITY_W-1:0] p;
    p = '0;
    for (int i = 0; i < PARITY_W; i++) begin
      p[i] = ^s[8*i +: 8];
    end
    return p;
  endfunction
`endif

endpackage

// File: rtl/add_round_key_stage_buf2.sv
// ark_buf2
//   Two-entry output FIFO for the AddRoundKey stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write request (ignored while full)
//   push_entry  : entry to store
//   pop         : read request (ignored while empty)
//   head        : oldest stored entry
//   not_empty   : at least one entry is held
//   not_full    : registered space-available flag; low while in reset and for
//                 the first cycle after release, never a function of pop
module ark_buf2
  import add_round_key_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ark_entry_t push_entry,
  input  logic       pop,
  output ark_entry_t head,
  output logic       not_empty,
  output logic       not_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  ark_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && not_full;
  assign do_pop    = pop && not_empty;
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (PTR_W + 1)'(1);
      2'b01:   count_next = count - (PTR_W + 1)'(1);
      default: count_next = count;
    endcase
  end

  // not_full is computed from the next occupancy so it is a plain flop
  // output, which keeps the upstream ready path free of out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      not_full <= (count_next != FULL_COUNT);
    end
  end

  // Payload storage needs no reset: nothing reads it until count says a
  // slot was written, and the parent blanks the outputs while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/add_round_key_stage.sv
// add_round_key_stage
//   AES AddRoundKey pipeline stage: XORs the MixColumns result with the round
//   key, tags it with a round number and buffers it in a 2-entry FIFO.
//   Parameters: NUM_ROUNDS (1..15, rounds per block), DEPTH (must be 2)
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready is registered)
//   state_in, key_in    : MixColumns output and matching round key
//   in_first            : marks round 1 of a new block
//   out_valid/out_ready : downstream handshake on the head entry
//   state_out           : state_in ^ key_in of the head entry
//   out_round, out_last : head round number, high when it is NUM_ROUNDS
//   seq_err             : one-cycle pulse after an out-of-sequence accept
//   out_parity          : per-byte even parity of state_out (only when the
//                         ARK_PARITY_EN macro is defined)
module add_round_key_stage
  import add_round_key_stage_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic [AES_STATE_W-1:0] key_in,
  input  logic                   in_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic [ROUND_W-1:0]     out_round,
  output logic                   out_last,
  output logic                   seq_err
`ifdef ARK_PARITY_EN
  ,
  output logic [15:0]            out_parity
`endif
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  if (DEPTH != 2) begin : g_bad_depth
    $error("add_round_key_stage: only DEPTH=2 is supported");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
    $error("add_round_key_stage: NUM_ROUNDS must be in 1..15");
  end

  logic               accept;
  logic               buf_not_empty;
  logic               buf_not_full;
  logic [ROUND_W-1:0] round_cnt;
  logic [ROUND_W-1:0] round_next;
  logic               seq_violation;
  ark_entry_t         push_entry;
  ark_entry_t         head;

  assign accept = in_valid && in_ready;

  // Round sequencing. A counter of 0 means idle (nothing since reset) and
  // LAST_ROUND means the previous block completed; only in_first may follow
  // either. in_first in the middle of a block is an abort: restart at 1 and
  // flag it.
  always_comb begin
    round_next    = round_cnt + ROUND_W'(1);
    seq_violation = 1'b0;
    if (in_first) begin
      round_next    = ROUND_W'(1);
      seq_violation = (round_cnt != '0) && (round_cnt != LAST_ROUND);
    end else if ((round_cnt == '0) || (round_cnt == LAST_ROUND)) begin
      round_next    = ROUND_W'(1);
      seq_violation = 1'b1;
    end
  end

  // Counter and error pulse only move on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt <= '0;
      seq_err   <= 1'b0;
    end else begin
      if (accept) round_cnt <= round_next;
      seq_err <= accept && seq_violation;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.state = state_in ^ key_in;
    push_entry.round = round_next;
`ifdef ARK_PARITY_EN
    push_entry.parity = byte_parity(state_in ^ key_in);
`endif
  end

  ark_buf2 #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (out_ready),
    .head      (head),
    .not_empty (buf_not_empty),
    .not_full  (buf_not_full)
  );

  // Outputs are blanked while empty so reset clears them at once and no
  // stale payload is visible after release.
  assign in_ready  = buf_not_full;
  assign out_valid = buf_not_empty;
  assign state_out = buf_not_empty ? head.state : '0;
  assign out_round = buf_not_empty ? head.round : '0;
  assign out_last  = buf_not_empty && (head.round == LAST_ROUND);
`ifdef ARK_PARITY_EN
  assign out_parity = buf_not_empty ? head.parity : '0;
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage
//   Self-checking bench for add_round_key_stage: a table of known vectors,
//   hand-written handshake/reset sequences and a randomized run, all checked
//   against a queue-based model of the stage.
module tb_add_round_key_stage;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic [127:0] key_in = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_last;
  logic         seq_err;
  logic [127:0] state_out;
  logic [3:0]   out_round;
`ifdef ARK_PARITY_EN
  logic [15:0]  out_parity;
`endif

  always #5 clk = ~clk;

  add_round_key_stage #(.NUM_ROUNDS(NR), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state_in (state_in),
    .key_in   (key_in),
    .in_first (in_first),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out),
    .out_round(out_round),
    .out_last (out_last),
    .seq_err  (seq_err)
`ifdef ARK_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  // Reference model: a queue of expected {xor, round} entries.
  typedef struct {
    logic [127:0] st;
    int           rnd;
  } exp_t;

  exp_t mq[$];
  int   m_round;
  bit   m_ready_en;
  bit   m_err;
  int   n_vec;
  int   n_err;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         first;
    logic [127:0] exp_state;
    logic [3:0]   exp_round;
    logic         exp_last;
    logic         exp_err;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

`ifdef ARK_PARITY_EN
  function automatic logic [15:0] ref_parity(input logic [127:0] s);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = s[8*i +: 8];
      p[i] = ($countones(b) % 2) == 1;
    end
    return p;
  endfunction
`endif

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("in_ready", in_ready, m_ready_en && (mq.size() < 2));
    checkOutput("out_valid", out_valid, mq.size() != 0);
    checkOutput("seq_err", seq_err, m_err);
    if (mq.size() != 0) begin
      checkOutput("state_out", state_out, mq[0].st);
      checkOutput("out_round", out_round, mq[0].rnd);
      checkOutput("out_last", out_last, mq[0].rnd == NR);
`ifdef ARK_PARITY_EN
      checkOutput("out_parity", out_parity, ref_parity(mq[0].st));
`endif
    end
  endtask

  // Called at a falling edge: drive, check, then advance the model across
  // one rising edge and return at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [127:0] st, input logic [127:0] k,
                               input logic f, input logic ordy, output bit acc);
    bit pop;
    in_valid  = v;
    state_in  = st;
    key_in    = k;
    in_first  = f;
    out_ready = ordy;
    checkModel();
    acc = v && m_ready_en && (mq.size() < 2);
    pop = ordy && (mq.size() != 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    m_err = 1'b0;
    if (acc) begin
      exp_t e;
      if (f) begin
        m_err   = (m_round >= 1) && (m_round <= NR - 1);
        m_round = 1;
      end else if (m_round == 0 || m_round == NR) begin
        m_err   = 1'b1;
        m_round = 1;
      end else begin
        m_round = m_round + 1;
      end
      e.st  = st ^ k;
      e.rnd = m_round;
      mq.push_back(e);
    end
    m_ready_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, ordy, acc);
  endtask

  task automatic doReset();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    mq.delete();
    m_round    = 0;
    m_err      = 1'b0;
    m_ready_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit           acc;
    int           idx;
    logic [127:0] d[3];

    n_vec = 0;
    n_err = 0;
    m_round = 0;
    m_err = 1'b0;
    m_ready_en = 1'b0;

    tbl[0] = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1,
               128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0, 1'b0};
    tbl[1] = '{128'h0, {128{1'b1}}, 1'b0, {128{1'b1}}, 4'd2, 1'b0, 1'b0};
    tbl[2] = '{{128{1'b1}}, {128{1'b1}}, 1'b0, 128'h0, 4'd3, 1'b0, 1'b0};
    tbl[3] = '{128'h0100, 128'h0003, 1'b1, 128'h0103, 4'd1, 1'b0, 1'b1};

    // Reset values while rst_n is low.
    @(negedge clk);
    checkOutput("rst out_valid", out_valid, 1'b0);
    checkOutput("rst in_ready", in_ready, 1'b0);
    checkOutput("rst seq_err", seq_err, 1'b0);
    checkOutput("rst state_out", state_out, '0);
    checkOutput("rst out_round", out_round, '0);
    checkOutput("rst out_last", out_last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b1);

    // Known-answer table, one accept at a time, head checked next cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, tbl[i].st, tbl[i].key, tbl[i].first, 1'b1, acc);
      checkOutput("tbl state_out", state_out, tbl[i].exp_state);
      checkOutput("tbl out_round", out_round, tbl[i].exp_round);
      checkOutput("tbl out_last", out_last, tbl[i].exp_last);
      checkOutput("tbl seq_err", seq_err, tbl[i].exp_err);
`ifdef ARK_PARITY_EN
      if (i == 3) checkOutput("tbl parity", out_parity, 16'h0002);
`endif
      idle(1, 1'b1);
    end

    // Full block back to back, then abort at round 5 of the next block.
    doReset();
    idle(1, 1'b1);
    for (int r = 1; r <= NR; r++) applyStimulus(1'b1, rand128(), rand128(), r == 1, 1'b1, acc);
    for (int r = 1; r <= 5; r++) applyStimulus(1'b1, rand128(), rand128(), r == 1, 1'b1, acc);
    applyStimulus(1'b1, rand128(), rand128(), 1'b1, 1'b1, acc);
    checkOutput("abort seq_err", seq_err, 1'b1);
    checkOutput("abort out_round", out_round, 4'd1);
    idle(3, 1'b1);

    // in_first=0 straight after reset.
    doReset();
    idle(1, 1'b1);
    applyStimulus(1'b1, rand128(), rand128(), 1'b0, 1'b1, acc);
    checkOutput("idle seq_err", seq_err, 1'b1);
    idle(3, 1'b1);

    // Backpressure: three offered, two taken, third after the first pop.
    for (int i = 0; i < 3; i++) d[i] = rand128();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, d[idx], 128'h5a, idx == 0, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("bp accepted", idx, 2);
    for (int c = 0; c < 6 && idx < 3; c++) begin
      applyStimulus(1'b1, d[idx], 128'h5a, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    checkOutput("bp third", idx, 3);
    idle(4, 1'b1);

    // Asynchronous reset with two entries buffered.
    applyStimulus(1'b1, rand128(), rand128(), 1'b1, 1'b0, acc);
    applyStimulus(1'b1, rand128(), rand128(), 1'b0, 1'b0, acc);
    checkOutput("pre-rst out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", out_valid, 1'b0);
    checkOutput("async state_out", state_out, '0);
    checkOutput("async in_ready", in_ready, 1'b0);
    doReset();
    idle(4, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, rand128(), rand128(),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, acc);
    end
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the round count per block (AES-128), range 1..15.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of output buffer entries; only 2 is supported.
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have in_valid, input, 1, meaning the upstream MixColumns result and key are valid.
REQ-006 SHALL have in_ready, output, 1, meaning the stage can accept this cycle.
REQ-007 SHALL have state_in, input, 128, the MixColumns output (bits 127:96 are column 0).
REQ-008 SHALL have key_in, input, 128, the round key aligned with state_in.
REQ-009 SHALL have in_first, input, 1, marking round 1 of a new block.
REQ-010 SHALL have out_valid, output, 1, meaning the head entry is valid.
REQ-011 SHALL have out_ready, input, 1, meaning downstream accepts the head entry.
REQ-012 SHALL have state_out, output, 128, equal to state_in XOR key_in of the head entry.
REQ-013 SHALL have out_round, output, 4, the round number of the head entry.
REQ-014 SHALL have out_last, output, 1, high when out_round equals NUM_ROUNDS.
REQ-015 SHALL have seq_err, output, 1, a one-cycle pulse on a round-sequence violation.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both high at a clock edge; pop SHALL occur when out_valid and out_ready are both high.
REQ-017 The stage SHALL be a 2-entry FIFO holding {state_in^key_in, round}; in_ready SHALL be registered-derived (count<2) and SHALL NOT depend combinationally on out_ready.
REQ-018 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear with out_valid=1 after edge N when the FIFO was empty.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and preserve order; push is blocked only when count=2.
REQ-020 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Round counter SHALL update on accept: in_first=1 sets round to 1; otherwise round increments.
REQ-022 An accept with in_first=0 when the counter is 0 (idle) or NUM_ROUNDS SHALL force round to 1 and pulse seq_err the following cycle.
REQ-023 An accept with in_first=1 when the counter is in 1..NUM_ROUNDS-1 (an aborted block) SHALL pulse seq_err and restart at round 1.
REQ-024 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-025 While rst_n=0: count=0, pointers=0, round counter=0, out_valid=0, in_ready=0, seq_err=0, state_out=0, out_round=0, out_last=0.
REQ-026 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-027 Reset mid-block SHALL discard all buffered entries, with no output after release until a new accept.

Configuration
REQ-028 With ARK_PARITY_EN defined, an output out_parity[15:0] SHALL exist, holding the even parity per byte of state_out, stored with the entry and reset to 0.
REQ-029 Without ARK_PARITY_EN, the out_parity port and its storage SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 A shared package SHALL hold the AES_STATE_W=128 and ROUND_W=4 constants and the entry typedef {state, round, parity}.
REQ-031 The FIFO SHALL be one sub-module, ark_buf2, with the XOR and round logic in the parent.

Verification
REQ-032 FIPS-197 vector: accept state_in=046681e5e0cb199a48f8d37a2806264c, key_in=a0fafe1788542cb123a339392a6c7605, in_first=1 -> next cycle state_out=a49c7ff2689f352b6b5bea43026a5049, out_round=1, out_last=0.
REQ-033 10 back-to-back accepts with out_ready=1 -> out_round 1..10 in order, out_last=1 only on round 10, seq_err never set.
REQ-034 Hold out_ready=0 and offer 3 inputs -> 2 accepted, in_ready=0, 3rd held; then out_ready=1 -> FIFO order preserved, 3rd accepted after the first pop.
REQ-035 Accept in_first=1 at round 5 -> seq_err pulses once and out_round=1; an accept with in_first=0 after reset -> seq_err pulses once.
REQ-036 Assert rst_n=0 with 2 entries buffered -> out_valid=0 and state_out=0 immediately, with no stale output after release.
REQ-037 With ARK_PARITY_EN defined, state_out byte 0x01 -> corresponding parity bit=1; byte 0x03 -> parity bit=0.
